// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multicycle RISC-V control path: opcodes, FSM state
// codes and the datapath mux encodings driven by the controller.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_MEMADR   = 4'd3,
        ST_MEMREAD  = 4'd4,
        ST_MEMWB    = 4'd5,
        ST_MEMWRITE = 4'd6,
        ST_EXECR    = 4'd7,
        ST_EXECI    = 4'd8,
        ST_ALUWB    = 4'd9,
        ST_BEQ      = 4'd10,
        ST_JAL      = 4'd11
    } state_t;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/instr_imm_decoder.sv
// Selects the immediate format for the extender straight from the opcode,
// independent of the control FSM state.
module instr_imm_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] Opcode,
    output logic [1:0] ImmSrc
);

    always_comb begin
        ImmSrc = IMM_I;
        case (Opcode)
            OP_SW:   ImmSrc = IMM_S;
            OP_BEQ:  ImmSrc = IMM_B;
            OP_JAL:  ImmSrc = IMM_J;
            default: ImmSrc = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Moore control FSM for the multicycle RISC-V core: sequences fetch, decode,
// execute, memory and writeback over a shared datapath and unified memory.
module multicycle_control_fsm
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] Opcode,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] ImmSrc,
    output logic       illegal_instr,
    output logic       instr_retired
);

    state_t state_reg, state_next;
    logic   branch, pc_update;

    instr_imm_decoder u_imm_dec (
        .Opcode (Opcode),
        .ImmSrc (ImmSrc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next    = state_reg;
        mem_req       = 1'b0;
        MemWrite      = 1'b0;
        AdrSrc        = 1'b0;
        IRWrite       = 1'b0;
        RegWrite      = 1'b0;
        ResultSrc     = RES_ALUOUT;
        ALUSrcA       = SRCA_PC;
        ALUSrcB       = SRCB_RD2;
        ALUOp         = ALUOP_ADD;
        illegal_instr = 1'b0;
        instr_retired = 1'b0;
        branch        = 1'b0;
        pc_update     = 1'b0;

        case (state_reg)
            ST_IDLE: state_next = ST_FETCH;
            ST_FETCH: begin
                // PC+4 is computed alongside the read so the PC advances as the IR loads
                mem_req   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                IRWrite   = mem_ready;
                pc_update = mem_ready;
                if (mem_ready) state_next = ST_DECODE;
            end
            ST_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (Opcode)
                    OP_LW, OP_SW: state_next = ST_MEMADR;
                    OP_R:         state_next = ST_EXECR;
                    OP_I:         state_next = ST_EXECI;
                    OP_BEQ:       state_next = ST_BEQ;
                    OP_JAL:       state_next = ST_JAL;
                    default: begin
                        illegal_instr = 1'b1;
                        state_next    = ST_FETCH;
                    end
                endcase
            end
            ST_MEMADR: begin
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = SRCB_IMM;
                state_next = (Opcode == OP_LW) ? ST_MEMREAD : ST_MEMWRITE;
            end
            ST_MEMREAD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
                if (mem_ready) state_next = ST_MEMWB;
            end
            ST_MEMWB: begin
                ResultSrc     = RES_DATA;
                RegWrite      = 1'b1;
                instr_retired = 1'b1;
                state_next    = ST_FETCH;
            end
            ST_MEMWRITE: begin
                mem_req  = 1'b1;
                MemWrite = 1'b1;
                AdrSrc   = 1'b1;
                if (mem_ready) begin
                    instr_retired = 1'b1;
                    state_next    = ST_FETCH;
                end
            end
            ST_EXECR: begin
                ALUSrcA    = SRCA_RD1;
                ALUOp      = ALUOP_FUNCT;
                state_next = ST_ALUWB;
            end
            ST_EXECI: begin
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = SRCB_IMM;
                ALUOp      = ALUOP_FUNCT;
                state_next = ST_ALUWB;
            end
            ST_JAL: begin
                // Jump target already sits in ALUOut; ALU forms the link address OldPC+4
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_FOUR;
                pc_update  = 1'b1;
                state_next = ST_ALUWB;
            end
            ST_ALUWB: begin
                RegWrite      = 1'b1;
                instr_retired = 1'b1;
                state_next    = ST_FETCH;
            end
            ST_BEQ: begin
                ALUSrcA       = SRCA_RD1;
                ALUOp         = ALUOP_SUB;
                branch        = 1'b1;
                instr_retired = 1'b1;
                state_next    = ST_FETCH;
            end
            default: state_next = ST_IDLE;
        endcase

        PCWrite = (branch & Zero) | pc_update;
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboarded bench for the multicycle control FSM: stimulus queues the
// expected output vector for every driven cycle, a monitor compares on negedge.
module tb_multicycle_control_fsm;
    import riscv_ctrl_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [6:0] Opcode;
    logic       Zero;
    logic       mem_ready;
    logic       mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
    logic       illegal_instr, instr_retired;

    int n_cmp = 0;
    int n_err = 0;

    logic [17:0] exp_q[$];
    string       name_q[$];

    multicycle_control_fsm dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .Opcode        (Opcode),
        .Zero          (Zero),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .MemWrite      (MemWrite),
        .AdrSrc        (AdrSrc),
        .IRWrite       (IRWrite),
        .PCWrite       (PCWrite),
        .RegWrite      (RegWrite),
        .ResultSrc     (ResultSrc),
        .ALUSrcA       (ALUSrcA),
        .ALUSrcB       (ALUSrcB),
        .ALUOp         (ALUOp),
        .ImmSrc        (ImmSrc),
        .illegal_instr (illegal_instr),
        .instr_retired (instr_retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Field order: req mw adr irw pcw rw | rs sa sb op imm | ill ret
    function automatic logic [17:0] mk(input logic req, input logic mw, input logic adr,
                                       input logic irw, input logic pcw, input logic rw,
                                       input logic [1:0] rs, input logic [1:0] sa,
                                       input logic [1:0] sb, input logic [1:0] op,
                                       input logic [1:0] imm, input logic ill, input logic ret);
        return {req, mw, adr, irw, pcw, rw, rs, sa, sb, op, imm, ill, ret};
    endfunction

    function automatic logic [17:0] outs();
        return {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
                ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, illegal_instr, instr_retired};
    endfunction

    task automatic chk(input string name, input logic [17:0] got, input logic [17:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %b required %b", name, got, want);
        end else begin
            $display("ok   %s: %b", name, got);
        end
    endtask

    task automatic step(input string name, input logic mr, input logic [17:0] v);
        mem_ready = mr;
        exp_q.push_back(v);
        name_q.push_back(name);
        @(posedge clk);
        #1;
    endtask

    // Monitor: one comparison per queued cycle, sampled mid-cycle
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) chk(name_q.pop_front(), outs(), exp_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        Zero      = 1'b0;
        mem_ready = 1'b0;
        Opcode    = OP_LW;
        @(posedge clk);
        #1;
        step("reset0", 1'b1, mk(0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00, 0,0));
        step("reset1", 1'b1, mk(0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00, 0,0));
        rst_n = 1'b1;
        step("idle", 1'b1, mk(0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00, 0,0));

        // lw, zero-wait memory: 5 cycles
        step("lw.fetch",   1'b1, mk(1,0,0,1,1,0, 2'b10,2'b00,2'b10,2'b00,2'b00, 0,0));
        step("lw.decode",  1'b1, mk(0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,2'b00, 0,0));
        step("lw.memadr",  1'b1, mk(0,0,0,0,0,0, 2'b00,2'b10,2'b01,2'b00,2'b00, 0,0));
        step("lw.memread", 1'b1, mk(1,0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00, 0,0));
        step("lw.memwb",   1'b1, mk(0,0,0,0,0,1, 2'b01,2'b00,2'b00,2'b00,2'b00, 0,1));

        // sw with three wait cycles in MEMWRITE
        Opcode = OP_SW;
        step("sw.fetch",   1'b1, mk(1,0,0,1,1,0, 2'b10,2'b00,2'b10,2'b00,2'b01, 0,0));
        step("sw.decode",  1'b1, mk(0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,2'b01, 0,0));
        step("sw.memadr",  1'b1, mk(0,0,0,0,0,0, 2'b00,2'b10,2'b01,2'b00,2'b01, 0,0));
        for (int i = 0; i < 3; i++)
            step($sformatf("sw.wait%0d", i), 1'b0,
                 mk(1,1,1,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b01, 0,0));
        step("sw.memwrite", 1'b1, mk(1,1,1,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b01, 0,1));

        // R-type with one fetch wait cycle
        Opcode = OP_R;
        step("r.fetchwait", 1'b0, mk(1,0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00,2'b00, 0,0));
        step("r.fetch",     1'b1, mk(1,0,0,1,1,0, 2'b10,2'b00,2'b10,2'b00,2'b00, 0,0));
        step("r.decode",    1'b0, mk(0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,2'b00, 0,0));
        step("r.execr",     1'b1, mk(0,0,0,0,0,0, 2'b00,2'b10,2'b00,2'b10,2'b00, 0,0));
        step("r.aluwb",     1'b1, mk(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00,2'b00, 0,1));

        // I-type ALU
        Opcode = OP_I;
        step("i.fetch",  1'b1, mk(1,0,0,1,1,0, 2'b10,2'b00,2'b10,2'b00,2'b00, 0,0));
        step("i.decode", 1'b1, mk(0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,2'b00, 0,0));
        step("i.execi",  1'b1, mk(0,0,0,0,0,0, 2'b00,2'b10,2'b01,2'b10,2'b00, 0,0));
        step("i.aluwb",  1'b1, mk(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00,2'b00, 0,1));

        // beq taken (Zero=1 throughout), then not taken
        Opcode = OP_BEQ;
        Zero   = 1'b1;
        step("beq1.fetch",  1'b1, mk(1,0,0,1,1,0, 2'b10,2'b00,2'b10,2'b00,2'b10, 0,0));
        step("beq1.decode", 1'b1, mk(0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,2'b10, 0,0));
        step("beq1.beq",    1'b1, mk(0,0,0,0,1,0, 2'b00,2'b10,2'b00,2'b01,2'b10, 0,1));
        Zero = 1'b0;
        step("beq2.fetch",  1'b1, mk(1,0,0,1,1,0, 2'b10,2'b00,2'b10,2'b00,2'b10, 0,0));
        step("beq2.decode", 1'b1, mk(0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,2'b10, 0,0));
        step("beq2.beq",    1'b1, mk(0,0,0,0,0,0, 2'b00,2'b10,2'b00,2'b01,2'b10, 0,1));

        // jal
        Opcode = OP_JAL;
        step("jal.fetch",  1'b1, mk(1,0,0,1,1,0, 2'b10,2'b00,2'b10,2'b00,2'b11, 0,0));
        step("jal.decode", 1'b1, mk(0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,2'b11, 0,0));
        step("jal.jal",    1'b1, mk(0,0,0,0,1,0, 2'b00,2'b01,2'b10,2'b00,2'b11, 0,0));
        step("jal.aluwb",  1'b1, mk(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00,2'b11, 0,1));

        // illegal opcode: two cycles, then straight back to FETCH
        Opcode = 7'b0000000;
        step("ill.fetch",  1'b1, mk(1,0,0,1,1,0, 2'b10,2'b00,2'b10,2'b00,2'b00, 0,0));
        step("ill.decode", 1'b1, mk(0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,2'b00, 1,0));

        // lw stalled in MEMREAD, then asynchronous reset mid-cycle
        Opcode = OP_LW;
        step("lw2.fetch",     1'b1, mk(1,0,0,1,1,0, 2'b10,2'b00,2'b10,2'b00,2'b00, 0,0));
        step("lw2.decode",    1'b1, mk(0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,2'b00, 0,0));
        step("lw2.memadr",    1'b1, mk(0,0,0,0,0,0, 2'b00,2'b10,2'b01,2'b00,2'b00, 0,0));
        step("lw2.memreadw",  1'b0, mk(1,0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00, 0,0));
        #1;
        chk("lw2.stillwait", outs(), mk(1,0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00, 0,0));
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_reset", outs(), mk(0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00, 0,0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("idle2",  1'b0, mk(0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00, 0,0));
        step("fetch2", 1'b0, mk(1,0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00,2'b00, 0,0));

        repeat (2) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Multicycle RISC-V control unit that sequences the shared datapath across Fetch, Decode, Execute, Memory and Writeback steps. It drives the datapath muxes and enables, emits ALUOp to the existing ALU decoder, and talks to a single unified instruction/data memory through a req/ready handshake. It replaces single-cycle main decoding in the multicycle core.

## Interface
- No parameters; opcodes, state codes and mux encodings come from the shared package.
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- Opcode  in  7  instr[6:0] from the instruction register
- Zero  in  1  ALU zero flag
- mem_ready  in  1  memory accepted the write or returned read data this cycle
- mem_req  out  1  memory access request
- MemWrite  out  1  request is a write (valid only with mem_req)
- AdrSrc  out  1  memory address: 0 = PC, 1 = Result
- IRWrite  out  1  load the instruction register and OldPC
- PCWrite  out  1  PC enable: (Branch & Zero) | PCUpdate
- RegWrite  out  1  register file write
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = RD1
- ALUSrcB  out  2  00 = RD2, 01 = ImmExt, 10 = constant 4
- ALUOp  out  2  00 = add, 01 = sub/branch, 10 = funct-decoded
- ImmSrc  out  2  00 = I, 01 = S, 10 = B, 11 = J; combinational from Opcode
- illegal_instr  out  1  one-cycle pulse in DECODE on an unsupported opcode
- instr_retired  out  1  one-cycle pulse on the final cycle of each instruction

## Operation
- Supported opcodes:
  - lw 0000011, sw 0100011, R 0110011, I-ALU 0010011: ImmSrc 00 for lw and I-ALU, 01 for sw.
  - beq 1100011: ImmSrc 10.
  - jal 1101111: ImmSrc 11.
  - Any other opcode: ImmSrc 00.
- Moore FSM: outputs depend on state only, except that the Fetch/MemRead/MemWrite enables are qualified by mem_ready and PCWrite uses Zero. Unlisted outputs are 0.
- IDLE: all outputs 0 → FETCH.
- FETCH: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite=PCUpdate=mem_ready.
  - Holds until mem_ready, then → DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch/jump target into ALUOut).
  - lw/sw → MEMADR; R → EXECR; I → EXECI; beq → BEQ; jal → JAL.
  - Otherwise: illegal_instr=1, → FETCH.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00 → MEMREAD (lw) or MEMWRITE (sw).
- MEMREAD: mem_req=1, AdrSrc=1, ResultSrc=00; holds until mem_ready → MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, instr_retired=1 → FETCH.
- MEMWRITE: mem_req=1, MemWrite=1, AdrSrc=1, ResultSrc=00; holds until mem_ready, then instr_retired=1 → FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10 → ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10 → ALUWB.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1 → ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, instr_retired=1 → FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1, instr_retired=1 → FETCH.
- mem_ready outside FETCH/MEMREAD/MEMWRITE is ignored.
- mem_req and MemWrite are held stable while waiting for mem_ready.

## Timing
- Reset: rst_n low forces state=IDLE asynchronously, so every output except ImmSrc is 0 immediately.
  - Any outstanding memory request is dropped; reset mid-operation needs no cleanup.
  - The first FETCH is the second rising edge after rst_n deasserts.
- Cycle counts with zero-wait memory (mem_ready=1 on the first request cycle):
  - lw 5; sw 4; R, I and jal 4; beq 3; illegal 2.
- Each memory wait cycle adds exactly one cycle.
- PCWrite is combinational from Branch & Zero | PCUpdate; it is high in BEQ only if Zero=1 in that cycle.
- instr_retired is high for exactly one cycle per legal instruction and is never high in the same cycle as illegal_instr.

## Structure
- Shared package `riscv_ctrl_pkg`:
  - opcode constants;
  - 4-bit state enum: IDLE 0, FETCH 1, DECODE 2, MEMADR 3, MEMREAD 4, MEMWB 5, MEMWRITE 6, EXECR 7, EXECI 8, ALUWB 9, BEQ 10, JAL 11;
  - ResultSrc, ALUSrcA, ALUSrcB, ALUOp and ImmSrc encodings.
- One natural sub-module: `instr_imm_decoder` (Opcode → ImmSrc, combinational).
- The state register and next-state/output logic stay in the top module.

## Test plan
- Reset: rst_n low while the FSM is in MEMREAD with mem_ready=0 → mem_req=0 immediately; after release, IDLE, then FETCH with mem_req=1, AdrSrc=0.
- lw, ready always 1 → states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 with ResultSrc=01 in cycle 5; instr_retired pulses once.
- sw with mem_ready held 0 for 3 cycles in MEMWRITE → mem_req=1 and MemWrite=1 stable for 4 cycles, then FETCH; RegWrite never asserted.
- beq twice, Zero=1 then Zero=0 → PCWrite=1 in the first BEQ cycle, PCWrite=0 in the second; each instruction takes 3 cycles.
- jal → PCWrite=1 in the JAL state, RegWrite=1 with ResultSrc=00 in ALUWB; ImmSrc=11 throughout.
- Opcode 0000000 in DECODE → illegal_instr=1 for one cycle, no RegWrite/MemWrite, FETCH on the next cycle.
